encoder_frame_sched: RTL
========================

# encoder_frame_sched

Snapshot scheduler and byte serializer for the lens quadrature-decoder counters (zoom, focus, iris, ...). It latches all channel counts atomically on a sync pulse, or on an internal timeout when sync is absent. The latched set goes out as a checksummed byte frame on a valid/ready stream, which feeds the UART/packet transmitter.

## Interface
- CHANNELS, 3: number of decoder counters sampled; range 1..8.
- BITS, 32: width of each counter; must be a multiple of 8, range 8..32.
- TIMEOUT, 1_000_000: clocks without a trigger before a self-triggered frame; 0 disables the timeout.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  triggers accepted only while high.
- sync_in  in  1  asynchronous frame-sync pulse (for example genlock), minimum 3 clk high.
- cnt_flat  in  CHANNELS*BITS  decoder counts; channel k occupies bits [k*BITS +: BITS].
- out_data  out  8  frame byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the byte when valid and ready are both high.
- out_last  out  1  high with the checksum byte.
- busy  out  1  frame in progress, from snapshot until the last byte is accepted.

## Operation
- **sync_in path:** 2-FF synchronizer, then rising-edge detect, gives a one-cycle sync_evt.
- **Trigger:** `trig = enable & (sync_evt | tmo_evt)`.
- **Timeout timer:**
  - Counts clocks while enable is high and TIMEOUT != 0.
  - Cleared by any trig, by enable low, and by reset.
  - tmo_evt fires when the count reaches TIMEOUT-1.
- **trig while IDLE:**
  - Latch all of cnt_flat into the snapshot register in the same cycle.
  - Latch flags: bit0 = overrun_pend, bit1 = trigger was a timeout and not a sync; bits 7..2 = 0.
  - Clear overrun_pend and go to HDR.
- **trig while busy:** the trigger is dropped, overrun_pend is set, and the snapshot is not disturbed.
- **Simultaneous sync_evt and tmo_evt:** treated as a sync trigger, flag bit1 = 0.
- **Frame byte order:** 0xA5, seq, flags, then channel 0..CHANNELS-1 with each channel's BITS/8 bytes LSB first, then checksum.
  - Frame length = 4 + CHANNELS*BITS/8 bytes.
- **Checksum:** sum mod 256 of every preceding byte in the frame, header included.
- **seq:** 8-bit, reset to 0, increments by 1 (wrapping 0xFF to 0x00) when the checksum byte is accepted.
- **FSM states and transitions:**
  - IDLE to HDR on trig.
  - HDR to SEQ to FLAGS to DATA, each on handshake.
  - DATA holds a byte index 0..CHANNELS*BITS/8-1 and goes to CSUM on handshake of the last index.
  - CSUM to IDLE on handshake.
- **Stream rules:**
  - out_valid, once high, stays high with out_data and out_last stable until accepted.
  - No combinational path from out_ready to out_valid.
  - A new frame starts only after returning to IDLE.

## Timing
- **Reset values:** out_valid=0, out_last=0, out_data=0x00, busy=0, state=IDLE, seq=0, overrun_pend=0, timer=0, snapshot=0, synchronizer flops=0.
- **Sync latency:**
  - sync_in rising before edge n is sampled by edge n; sync_evt is high after edge n+2.
  - Snapshot is taken at edge n+3; busy and out_valid (0xA5) are high after edge n+3.
- **Timeout latency:** tmo_evt is high in the cycle the counter equals TIMEOUT-1; the snapshot is taken at the next edge.
- **Throughput:** with out_ready held high, one byte per clock, so a frame occupies exactly 4 + CHANNELS*BITS/8 cycles.
- **Back-to-back frames:** after the CSUM handshake the FSM is in IDLE for at least one cycle before the next trig is accepted.
- **enable low mid-frame:** the current frame completes; only new triggers are blocked.
- **rst mid-frame:** immediate abort to reset values; a partial frame is never resumed.

## Structure
- **Package encoder_frame_pkg:**
  - Constants FRAME_MAGIC = 8'hA5, FLAG_OVERRUN = 0, FLAG_TIMEOUT = 1.
  - State enum {IDLE, HDR, SEQ, FLAGS, DATA, CSUM}.
  - Function frame_len(CHANNELS, BITS).
- **Sub-module sync_edge_detect:** 2-FF synchronizer plus rising-edge pulse, with clk and rst.
- **Everything else inline:** timer, snapshot register, FSM and byte mux with running checksum.

## Test plan
All scenarios use CHANNELS=2, BITS=16, so the frame length is 8 bytes.

- **Basic frame:** cnt0=0x1234, cnt1=0xFFFE, one sync pulse, ready high -> bytes A5 00 00 34 12 FE FF E8, out_last on E8; snapshot appears 3 clk after sync_in rises.
- **Atomic snapshot:** cnt_flat changes every cycle after the trigger -> the frame carries only the values present at the snapshot edge.
- **Overrun:** second sync arrives mid-frame -> first frame unchanged; next frame flags=0x01, seq=0x01; the following frame flags=0x00.
- **Timeout:** TIMEOUT=16, enable high, no sync -> frame starts 16 clk after enable rises with flags=0x02; sync on the tmo_evt cycle -> flags=0x00.
- **Backpressure:** out_ready randomly toggled -> byte sequence identical to ready-high run and out_data stable while valid && !ready; seq wraps 0xFF to 0x00 after 256 frames.
- **Reset mid-frame:** rst asserted after byte 3 -> out_valid=0 immediately; next frame seq=0x00 with a full 8-byte frame.

Source files
------------

// File: rtl/encoder_frame_pkg.sv
// ----------------------------------------------------------------------------
// encoder_frame_pkg
// Shared definitions for the encoder frame scheduler: frame magic byte,
// flag bit positions, serializer state encoding and frame length helper.
// ----------------------------------------------------------------------------
package encoder_frame_pkg;

    localparam logic [7:0]  FRAME_MAGIC  = 8'hA5;
    localparam int unsigned FLAG_OVERRUN = 0;
    localparam int unsigned FLAG_TIMEOUT = 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        FLAGS,
        DATA,
        CSUM
    } state_e;

    // Header (magic, seq, flags) + payload + checksum
    function automatic int unsigned frame_len(input int unsigned channels,
                                              input int unsigned bits);
        return 4 + (channels * bits) / 8;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchronizer for an asynchronous level input followed by a
// registered rising-edge detector producing a one-cycle pulse.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   async_in : asynchronous input (must stay high >= 3 clk)
//   pulse    : one-cycle pulse, high two edges after the first sampling edge
// ----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        meta_d  = async_in;
        sync_d  = meta_q;
        prev_d  = sync_q;
        // Edge pulse is registered so it leaves a clean flop output
        pulse_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/encoder_frame_sched.sv
// ----------------------------------------------------------------------------
// encoder_frame_sched
// Atomically snapshots all decoder counters on a sync pulse (or an internal
// timeout when sync is absent) and serializes the snapshot as a checksummed
// byte frame: A5, seq, flags, payload (channel 0 first, LSB first), checksum.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : gates acceptance of new triggers
//   sync_in    : asynchronous frame-sync pulse
//   cnt_flat   : decoder counts, channel k at [k*BITS +: BITS]
//   out_data/out_valid/out_ready/out_last : byte stream, last = checksum
//   busy       : frame in progress (snapshot until checksum accepted)
// ----------------------------------------------------------------------------
module encoder_frame_sched
    import encoder_frame_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned BITS     = 32,
    parameter int unsigned TIMEOUT  = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sync_in,
    input  logic [CHANNELS*BITS-1:0]   cnt_flat,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy
);

    localparam int unsigned NBYTES = frame_len(CHANNELS, BITS) - 4;
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT != 0) ? TW'(TIMEOUT - 1) : '0;

    state_e                   state_q, state_d;
    logic [CHANNELS*BITS-1:0] snap_q, snap_d;
    logic [7:0]               flags_q, flags_d;
    logic [7:0]               seq_q, seq_d;
    logic [7:0]               csum_q, csum_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     overrun_q, overrun_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;

    logic          sync_evt;
    logic          tmo_evt;
    logic          trig;
    logic          hs;
    logic [IW-1:0] sel_idx;
    logic [7:0]    snap_byte;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sync_in),
        .pulse    (sync_evt)
    );

    assign tmo_evt = (TIMEOUT != 0) && enable && (timer_q == TMO_LAST);
    assign trig    = enable & (sync_evt | tmo_evt);
    assign hs      = valid_q & out_ready;

    // Payload byte to present next: byte 0 when leaving FLAGS, idx+1 in DATA
    always_comb begin
        sel_idx   = (state_q == DATA) ? idx_q + 1'b1 : '0;
        snap_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (sel_idx == IW'(i)) snap_byte = snap_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        flags_d   = flags_q;
        seq_d     = seq_q;
        csum_d    = csum_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;

        if (!enable || trig || TIMEOUT == 0) timer_d = '0;
        else                                 timer_d = timer_q + 1'b1;

        // A trigger during a frame is dropped but remembered for the next one
        if (trig && state_q != IDLE) overrun_d = 1'b1;

        // csum_q always holds the sum of all bytes presented so far
        case (state_q)
            IDLE: if (trig) begin
                snap_d                = cnt_flat;
                flags_d               = '0;
                flags_d[FLAG_OVERRUN] = overrun_q;
                flags_d[FLAG_TIMEOUT] = tmo_evt & ~sync_evt;
                overrun_d             = 1'b0;
                state_d               = HDR;
                data_d                = FRAME_MAGIC;
                csum_d                = FRAME_MAGIC;
                valid_d               = 1'b1;
                last_d                = 1'b0;
            end
            HDR: if (hs) begin
                state_d = SEQ;
                data_d  = seq_q;
                csum_d  = csum_q + seq_q;
            end
            SEQ: if (hs) begin
                state_d = FLAGS;
                data_d  = flags_q;
                csum_d  = csum_q + flags_q;
            end
            FLAGS: if (hs) begin
                state_d = DATA;
                idx_d   = '0;
                data_d  = snap_byte;
                csum_d  = csum_q + snap_byte;
            end
            DATA: if (hs) begin
                if (idx_q == LAST_IDX) begin
                    state_d = CSUM;
                    data_d  = csum_q;
                    last_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = snap_byte;
                    csum_d = csum_q + snap_byte;
                end
            end
            CSUM: if (hs) begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                seq_d   = seq_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            flags_q   <= '0;
            seq_q     <= '0;
            csum_q    <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            flags_q   <= flags_d;
            seq_q     <= seq_d;
            csum_q    <= csum_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);

endmodule
